// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  // Control states; 2-bit encoding leaves one spare code that recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 32;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit combinational full adder: the only arithmetic cell in the datapath.
module fa (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  always_comb begin
    p    = a ^ b;
    sum  = p ^ cin;
    cout = (a & b) | (cin & p);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple-carry adder: A + B + c, one bit per clock, LSB first.
// Operands enter on a valid/ready handshake accepted only in IDLE; the
// result is held in DONE until the consumer takes it.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             msb_cin;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_bit;

  // Single full-adder cell working on the current LSBs and the carry flop.
  fa u_fa (
    .sum  (fa_s),
    .cout (fa_c),
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry)
  );

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign last_bit = (state == RUN) && (cnt == LAST);
  // Signed overflow: carry into the MSB differs from carry out of it.
  assign ovf      = msb_cin ^ cout;

  // Control: IDLE -> RUN on accept, RUN -> DONE after WIDTH bits, DONE -> IDLE on handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: if (last_bit) begin
          state     <= DONE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: load operands on accept, then shift one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= c;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
      carry  <= fa_c;
      // Hold on the final bit so the counter never wraps inside an operation.
      if (!last_bit) cnt <= cnt + CW'(1);
    end
  end

  // Result registers: updated only on the final bit, held everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum     <= '0;
      cout    <= 1'b0;
      msb_cin <= 1'b0;
    end else if (last_bit) begin
      sum     <= {fa_s, sum_sh[WIDTH-1:1]};
      cout    <= fa_c;
      msb_cin <= carry;
    end
  end

endmodule
